// File: rtl/kt_seq.sv
// kt_seq: program sequencer for the KT-series cores.
// Owns the PC and executes the control-flow opcodes: relative jumps,
// skip-on-zero/nonzero, forward call, return, and halt. Calls and returns
// go through a small hardware return stack.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   instruction_i  instruction at pc_o
//   instr_valid_i  instruction_i is valid this cycle
//   stall_i        freeze all state this cycle (highest priority)
//   r_value_i      R register value used by the skip tests
//   run_i          resume from HALTED
//   pc_o           current program counter (registered)
//   halted_o       sequencer is in HALTED
//   stack_depth_o  number of occupied return-stack entries
//   stack_err_o    sticky stack overflow/underflow flag
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_RUN  | one instruction per cycle when valid and not stalled
// ST_HALT | PC frozen, instructions ignored; run_i steps PC and resumes

module kt_seq #(
    parameter int PC_W        = 8,
    parameter int DATA_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_PC    = 0
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic [7:0]                     instruction_i,
    input  logic                           instr_valid_i,
    input  logic                           stall_i,
    input  logic [DATA_W-1:0]              r_value_i,
    input  logic                           run_i,
    output logic [PC_W-1:0]                pc_o,
    output logic                           halted_o,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_depth_o,
    output logic                           stack_err_o
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } state_t;

    state_t              r_state;
    logic [PC_W-1:0]     r_pc;
    logic                r_halted;
    logic [DEPTH_W-1:0]  r_depth;
    logic                r_err;
    logic [PC_W-1:0]     r_stack [STACK_DEPTH];

    logic [PC_W-1:0]     w_off;
    logic [PC_W-1:0]     w_pc_inc;
    logic [PC_W-1:0]     w_pc_nxt;
    logic                w_push;
    logic                w_pop;
    logic                w_err_set;
    logic                w_halt;
    logic                w_resume;
    logic                w_full;
    logic                w_empty;
    logic [IDX_W-1:0]    w_push_idx;
    logic [IDX_W-1:0]    w_pop_idx;

    assign w_off      = PC_W'(instruction_i[3:0]);
    assign w_pc_inc   = r_pc + PC_W'(1);
    assign w_full     = (r_depth == DEPTH_W'(STACK_DEPTH));
    assign w_empty    = (r_depth == '0);
    // The top of stack is entry depth-1; the next free slot is entry depth.
    assign w_push_idx = IDX_W'(r_depth);
    assign w_pop_idx  = IDX_W'(r_depth - DEPTH_W'(1));

    always_comb begin
        w_pc_nxt  = r_pc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_err_set = 1'b0;
        w_halt    = 1'b0;
        w_resume  = 1'b0;
        if (!stall_i) begin
            if (r_state == ST_HALT) begin
                if (run_i) begin
                    w_pc_nxt = w_pc_inc;
                    w_resume = 1'b1;
                end
            end else if (instr_valid_i) begin
                casez (instruction_i)
                    8'b1100_????: w_pc_nxt = r_pc + w_off;
                    8'b1101_????: w_pc_nxt = r_pc - w_off;
                    8'b1010_????: begin
                        if (w_full) begin
                            w_pc_nxt  = w_pc_inc;
                            w_err_set = 1'b1;
                        end else begin
                            w_push   = 1'b1;
                            w_pc_nxt = r_pc + w_off;
                        end
                    end
                    8'hE0: w_pc_nxt = (r_value_i == '0) ? r_pc + PC_W'(2) : w_pc_inc;
                    8'hE1: w_pc_nxt = (r_value_i != '0) ? r_pc + PC_W'(2) : w_pc_inc;
                    8'hE2: w_halt = 1'b1;
                    8'hE3: begin
                        if (w_empty) begin
                            w_pc_nxt  = w_pc_inc;
                            w_err_set = 1'b1;
                        end else begin
                            w_pop    = 1'b1;
                            w_pc_nxt = r_stack[w_pop_idx];
                        end
                    end
                    default: w_pc_nxt = w_pc_inc;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= ST_RUN;
            r_pc     <= PC_W'(RESET_PC);
            r_halted <= 1'b0;
            r_depth  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_pc <= w_pc_nxt;
            if (w_halt) begin
                r_state  <= ST_HALT;
                r_halted <= 1'b1;
            end else if (w_resume) begin
                r_state  <= ST_RUN;
                r_halted <= 1'b0;
            end
            if (w_push) begin
                r_depth <= r_depth + DEPTH_W'(1);
            end else if (w_pop) begin
                r_depth <= r_depth - DEPTH_W'(1);
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Stack contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    assign pc_o          = r_pc;
    assign halted_o      = r_halted;
    assign stack_depth_o = r_depth;
    assign stack_err_o   = r_err;

endmodule

// File: tb/tb_kt_seq.sv
module tb_kt_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] instr = 8'h00;
    logic       valid = 1'b0;
    logic       stall = 1'b0;
    logic [7:0] rval = 8'h00;
    logic       run = 1'b0;
    logic [7:0] pc_o;
    logic       halted_o;
    logic [2:0] depth_o;
    logic       err_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    kt_seq dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .instruction_i (instr),
        .instr_valid_i (valid),
        .stall_i       (stall),
        .r_value_i     (rval),
        .run_i         (run),
        .pc_o          (pc_o),
        .halted_o      (halted_o),
        .stack_depth_o (depth_o),
        .stack_err_o   (err_o)
    );

    typedef struct {
        logic [7:0] instr;
        logic       valid;
        logic       stall;
        logic       run;
        logic [7:0] r;
        logic [7:0] pc;
        logic       h;
        logic [2:0] d;
        logic       e;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [7:0] i, logic v, logic s, logic rn, logic [7:0] r,
                                logic [7:0] pc, logic h, logic [2:0] d, logic e);
        vec_t x;
        x.instr = i; x.valid = v; x.stall = s; x.run = rn; x.r = r;
        x.pc = pc; x.h = h; x.d = d; x.e = e;
        return x;
    endfunction

    task automatic check(string nm, logic [7:0] epc, logic eh, logic [2:0] ed, logic ee);
        n_vec++;
        if (pc_o !== epc || halted_o !== eh || depth_o !== ed || err_o !== ee) begin
            n_err++;
            $display("FAIL %s: got pc=%0d halted=%0b depth=%0d err=%0b, want pc=%0d halted=%0b depth=%0d err=%0b",
                     nm, pc_o, halted_o, depth_o, err_o, epc, eh, ed, ee);
        end
    endtask

    task automatic drive(logic [7:0] i, logic v, logic s, logic rn, logic [7:0] r);
        instr = i; valid = v; stall = s; run = rn; rval = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        drive(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Reference model state: plain integers and a queue for the return stack.
    int m_pc;
    int m_stk[$];
    bit m_h;
    bit m_e;

    task automatic model_step(logic [7:0] i, logic v, logic s, logic rn, logic [7:0] r);
        int o;
        o = int'(i) % 16;
        if (s) return;
        if (m_h) begin
            if (rn) begin
                m_pc = (m_pc + 1) % 256;
                m_h = 0;
            end
            return;
        end
        if (!v) return;
        if (i / 16 == 12) m_pc = (m_pc + o) % 256;
        else if (i / 16 == 13) m_pc = (m_pc + 256 - o) % 256;
        else if (i / 16 == 10) begin
            if (m_stk.size() == 4) begin
                m_e = 1;
                m_pc = (m_pc + 1) % 256;
            end else begin
                m_stk.push_back((m_pc + 1) % 256);
                m_pc = (m_pc + o) % 256;
            end
        end
        else if (i == 8'hE0) m_pc = (m_pc + ((r == 0) ? 2 : 1)) % 256;
        else if (i == 8'hE1) m_pc = (m_pc + ((r != 0) ? 2 : 1)) % 256;
        else if (i == 8'hE2) m_h = 1;
        else if (i == 8'hE3) begin
            if (m_stk.size() == 0) begin
                m_e = 1;
                m_pc = (m_pc + 1) % 256;
            end else begin
                m_pc = m_stk.pop_back();
            end
        end
        else m_pc = (m_pc + 1) % 256;
    endtask

    initial begin
        logic [7:0] ri;
        logic       rv, rs, rr;
        logic [7:0] rrv;

        //                instr  v  s  run  R     pc   h  d  e
        tbl.push_back(mk(8'h00, 1, 0, 0, 8'd0,  8'd1,  0, 0, 0));
        tbl.push_back(mk(8'hC5, 1, 0, 0, 8'd0,  8'd6,  0, 0, 0));
        tbl.push_back(mk(8'hD3, 1, 0, 0, 8'd0,  8'd3,  0, 0, 0));
        tbl.push_back(mk(8'hC7, 1, 0, 0, 8'd0,  8'd10, 0, 0, 0));
        tbl.push_back(mk(8'hE0, 1, 0, 0, 8'd0,  8'd12, 0, 0, 0));
        tbl.push_back(mk(8'hE1, 1, 0, 0, 8'd0,  8'd13, 0, 0, 0));
        tbl.push_back(mk(8'hE1, 1, 0, 0, 8'd5,  8'd15, 0, 0, 0));
        tbl.push_back(mk(8'hC5, 1, 0, 0, 8'd0,  8'd20, 0, 0, 0));
        tbl.push_back(mk(8'hA4, 1, 0, 0, 8'd0,  8'd24, 0, 1, 0));
        tbl.push_back(mk(8'hE3, 1, 0, 0, 8'd0,  8'd21, 0, 0, 0));
        tbl.push_back(mk(8'hA4, 1, 0, 0, 8'd0,  8'd25, 0, 1, 0));
        tbl.push_back(mk(8'hE3, 1, 0, 0, 8'd0,  8'd22, 0, 0, 0));
        tbl.push_back(mk(8'hC0, 1, 0, 0, 8'd0,  8'd22, 0, 0, 0));
        tbl.push_back(mk(8'hC5, 0, 0, 0, 8'd0,  8'd22, 0, 0, 0));
        tbl.push_back(mk(8'hC5, 1, 1, 0, 8'd0,  8'd22, 0, 0, 0));
        tbl.push_back(mk(8'hE0, 1, 0, 0, 8'd7,  8'd23, 0, 0, 0));
        tbl.push_back(mk(8'h55, 1, 0, 0, 8'd0,  8'd24, 0, 0, 0));
        tbl.push_back(mk(8'hDF, 1, 0, 0, 8'd0,  8'd9,  0, 0, 0));
        tbl.push_back(mk(8'hD9, 1, 0, 0, 8'd0,  8'd0,  0, 0, 0));
        tbl.push_back(mk(8'hD2, 1, 0, 0, 8'd0,  8'd254,0, 0, 0));
        tbl.push_back(mk(8'hC5, 1, 0, 0, 8'd0,  8'd3,  0, 0, 0));
        tbl.push_back(mk(8'hD2, 1, 0, 0, 8'd0,  8'd1,  0, 0, 0));
        tbl.push_back(mk(8'hD3, 1, 0, 0, 8'd0,  8'd254,0, 0, 0));
        tbl.push_back(mk(8'hA1, 1, 0, 0, 8'd0,  8'd255,0, 1, 0));
        tbl.push_back(mk(8'hA1, 1, 0, 0, 8'd0,  8'd0,  0, 2, 0));
        tbl.push_back(mk(8'hE3, 1, 0, 0, 8'd0,  8'd0,  0, 1, 0));
        tbl.push_back(mk(8'hE3, 1, 0, 0, 8'd0,  8'd255,0, 0, 0));
        tbl.push_back(mk(8'hC8, 1, 0, 0, 8'd0,  8'd7,  0, 0, 0));
        tbl.push_back(mk(8'hE2, 1, 0, 0, 8'd0,  8'd7,  1, 0, 0));
        tbl.push_back(mk(8'hC5, 1, 0, 0, 8'd0,  8'd7,  1, 0, 0));
        tbl.push_back(mk(8'h00, 0, 1, 1, 8'd0,  8'd7,  1, 0, 0));
        tbl.push_back(mk(8'h00, 0, 0, 1, 8'd0,  8'd8,  0, 0, 0));

        #1 rst_n = 1'b0;
        #2 check("reset", 8'd0, 1'b0, 3'd0, 1'b0);
        #9 rst_n = 1'b1;

        foreach (tbl[k]) begin
            drive(tbl[k].instr, tbl[k].valid, tbl[k].stall, tbl[k].run, tbl[k].r);
            step();
            check($sformatf("tbl%0d", k), tbl[k].pc, tbl[k].h, tbl[k].d, tbl[k].e);
        end

        // Halt with a non-empty stack, ignore random traffic, resume, then reset mid-halt.
        drive(8'hA3, 1, 0, 0, 8'd0); step(); check("halt_call", 8'd11, 0, 3'd1, 0);
        drive(8'hD4, 1, 0, 0, 8'd0); step(); check("halt_bjmp", 8'd7, 0, 3'd1, 0);
        drive(8'hE2, 1, 0, 0, 8'd0); step(); check("halt_enter", 8'd7, 1, 3'd1, 0);
        for (int k = 0; k < 10; k++) begin
            drive(8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 8'($urandom));
            step();
            check($sformatf("halt_hold%0d", k), 8'd7, 1, 3'd1, 0);
        end
        drive(8'h00, 0, 1, 1, 8'd0); step(); check("halt_run_stalled", 8'd7, 1, 3'd1, 0);
        drive(8'h00, 0, 0, 1, 8'd0); step(); check("halt_run", 8'd8, 0, 3'd1, 0);
        drive(8'hE2, 1, 0, 0, 8'd0); step(); check("halt_again", 8'd8, 1, 3'd1, 0);
        drive(8'h00, 0, 0, 0, 8'd0);
        #1 rst_n = 1'b0;
        #1 check("reset_mid_halt", 8'd0, 0, 3'd0, 0);
        #1 rst_n = 1'b1;

        // Overflow and underflow of a four-entry stack.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(8'hA2, 1, 0, 0, 8'd0); step();
            check($sformatf("call%0d", k), 8'(2 * (k + 1)), 0, 3'(k + 1), 0);
        end
        drive(8'hA2, 1, 0, 0, 8'd0); step(); check("call_overflow", 8'd9, 0, 3'd4, 1);
        for (int k = 0; k < 4; k++) begin
            drive(8'hE3, 1, 0, 0, 8'd0); step();
            check($sformatf("ret%0d", k), 8'(7 - 2 * k), 0, 3'(3 - k), 1);
        end
        drive(8'hE3, 1, 0, 0, 8'd0); step(); check("ret_underflow", 8'd2, 0, 3'd0, 1);

        // Randomized traffic against the reference model.
        do_reset();
        m_pc = 0; m_stk.delete(); m_h = 0; m_e = 0;
        for (int k = 0; k < 1500; k++) begin
            case ($urandom_range(0, 9))
                0: ri = 8'hC0 | 8'($urandom_range(0, 15));
                1: ri = 8'hD0 | 8'($urandom_range(0, 15));
                2: ri = 8'hA0 | 8'($urandom_range(0, 15));
                3: ri = 8'hE0;
                4: ri = 8'hE1;
                5: ri = ($urandom_range(0, 3) == 0) ? 8'hE2 : 8'hE3;
                6: ri = 8'hE3;
                default: ri = 8'($urandom);
            endcase
            rv  = ($urandom_range(0, 7) != 0);
            rs  = ($urandom_range(0, 7) == 0);
            rr  = ($urandom_range(0, 3) == 0);
            rrv = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom);
            drive(ri, rv, rs, rr, rrv);
            model_step(ri, rv, rs, rr, rrv);
            step();
            check($sformatf("rand%0d", k), 8'(m_pc), m_h, 3'(m_stk.size()), m_e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
